piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, parallel word width in bits (legal range 2..16).
REQ-002 SHALL provide parameter MSB_FIRST, default 1: 1 = MSB shifted first, 0 = LSB shifted first.
REQ-003 SHALL provide port Clock  input  1  rising-edge clock for all state.
REQ-004 SHALL provide port Reset  input  1  synchronous, active-low reset (0 = reset, sampled on the rising edge of Clock).
REQ-005 SHALL provide port Data_In  input  WIDTH  parallel word to serialize.
REQ-006 SHALL provide port In_Valid  input  1  upstream asserts when Data_In holds a word.
REQ-007 SHALL provide port In_Ready  output  1  block can accept a word this cycle.
REQ-008 SHALL provide port Serial_Out  output  1  serial bit stream.
REQ-009 SHALL provide port Out_Valid  output  1  Serial_Out carries a frame bit this cycle.
REQ-010 SHALL provide port Frame_Start  output  1  high only on the first bit of each frame.
REQ-011 SHALL provide port Busy  output  1  high while a frame is in progress (state != IDLE).

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT and PARITY; PARITY exists only when the Configuration macro is defined.
REQ-013 SHALL accept a word on a rising edge where In_Valid=1 and In_Ready=1, and SHALL capture Data_In into an internal shift register only at that edge.
REQ-014 SHALL drive In_Ready=1 in IDLE and in the final bit cycle of a frame; In_Ready SHALL be 0 in all other cycles.
REQ-015 SHALL, on acceptance, enter SHIFT and present the first bit on Serial_Out in the cycle after the accepting edge (latency 1), with Frame_Start=1 and Out_Valid=1.
REQ-016 SHALL shift out one bit per cycle for WIDTH consecutive cycles, with Out_Valid=1 throughout, in the order set by MSB_FIRST.
REQ-017 SHALL use a bit counter of width ceil(log2(WIDTH)), loaded with WIDTH-1 on acceptance and decremented each SHIFT cycle; the count reaching 0 marks the last data bit.
REQ-018 SHALL, when a new word is accepted in the final bit cycle, begin the next frame on the very next cycle with no gap; Frame_Start SHALL pulse again.
REQ-019 SHALL, when the final bit cycle completes with no acceptance, return to IDLE with Serial_Out=0, Out_Valid=0 and Frame_Start=0.
REQ-020 SHALL ignore In_Valid and Data_In while In_Ready=0; changes to Data_In during a frame SHALL NOT affect the bits being shifted.
REQ-021 SHALL hold Serial_Out=0 whenever Out_Valid=0.
REQ-022 SHALL drive all outputs from registers, with no combinational path from inputs to Serial_Out, Out_Valid or Frame_Start.

Reset
REQ-023 SHALL, while Reset=0 at a rising edge, force state IDLE, clear the shift register and counter, and set Serial_Out=0, Out_Valid=0, Frame_Start=0, Busy=0 and In_Ready=0.
REQ-024 SHALL drive In_Ready=1 in the first cycle after Reset returns to 1.
REQ-025 SHALL, when reset occurs mid-frame, discard the frame; no remaining bits SHALL be emitted after reset is released.

Configuration
REQ-026 SHALL, when macro PISO_SERIALIZER_PARITY_EN is defined, append one even-parity bit (XOR of all WIDTH data bits) in PARITY state after the last data bit, with Out_Valid=1; the PARITY cycle, not the last data bit cycle, is then the final bit cycle for REQ-014 and REQ-018.
REQ-027 SHALL, when PISO_SERIALIZER_PARITY_EN is undefined, have no PARITY state, giving frames of exactly WIDTH bits.

Verification
REQ-028 SHALL cover basic frame: WIDTH=4, MSB_FIRST=1, accept 4'b1011 -> Serial_Out 1,0,1,1 on 4 consecutive cycles, Frame_Start=1 on the first only, then return to IDLE.
REQ-029 SHALL cover back-to-back frames: 4'b1011 then 4'b0100 with In_Valid held high -> 8 contiguous bits 1,0,1,1,0,1,0,0 with Out_Valid never low between frames and Frame_Start pulsed twice.
REQ-030 SHALL cover LSB order: MSB_FIRST=0, accept 4'b0110 -> Serial_Out 0,1,1,0.
REQ-031 SHALL cover data stability: accept 4'b1001 and change Data_In to 4'b1111 on the second bit cycle -> output remains 1,0,0,1.
REQ-032 SHALL cover mid-frame reset: Reset=0 after 2 bits of 4'b1111 -> Out_Valid=0 and Serial_Out=0 from the next cycle, and In_Ready=1 in the first cycle after release.
REQ-033 SHALL cover parity: with PISO_SERIALIZER_PARITY_EN defined, accept 4'b1011 -> Serial_Out 1,0,1,1,1; with 4'b0110 -> Serial_Out 0,1,1,0,0.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer with valid/ready intake and gapless back-to-back frames.
// Define PISO_SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Data_In,
  input  logic             In_Valid,
  output logic             In_Ready,
  output logic             Serial_Out,
  output logic             Out_Valid,
  output logic             Frame_Start,
  output logic             Busy
);

  localparam int CW = $clog2(WIDTH);

`ifdef PISO_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             accept;
  logic             so_nxt, ov_nxt, fs_nxt, busy_nxt, rdy_nxt, final_nxt;
`ifdef PISO_SERIALIZER_PARITY_EN
  logic             par, par_nxt;
`endif

  assign accept = In_Valid & In_Ready;

  function automatic logic head(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
`ifdef PISO_SERIALIZER_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      sreg  <= sreg_nxt;
      cnt   <= cnt_nxt;
`ifdef PISO_SERIALIZER_PARITY_EN
      par   <= par_nxt;
`endif
    end
  end

  // cnt counts data bits still to come after the one currently on Serial_Out
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
`ifdef PISO_SERIALIZER_PARITY_EN
    par_nxt   = par;
`endif
    case (state)
      IDLE: if (accept) state_nxt = SHIFT;
      SHIFT: begin
        if (cnt != '0) begin
          cnt_nxt  = cnt - 1'b1;
          sreg_nxt = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
        end else begin
`ifdef PISO_SERIALIZER_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = accept ? SHIFT : IDLE;
`endif
        end
      end
`ifdef PISO_SERIALIZER_PARITY_EN
      PARITY: state_nxt = accept ? SHIFT : IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
    if (accept) begin
      sreg_nxt = Data_In;
      cnt_nxt  = CW'(WIDTH - 1);
`ifdef PISO_SERIALIZER_PARITY_EN
      par_nxt  = ^Data_In;
`endif
    end
  end

  // Outputs are precomputed from next state so they can be registered
  always_comb begin
    ov_nxt   = (state_nxt != IDLE);
    busy_nxt = (state_nxt != IDLE);
    fs_nxt   = accept;
    so_nxt   = 1'b0;
    if (state_nxt == SHIFT) so_nxt = head(sreg_nxt);
`ifdef PISO_SERIALIZER_PARITY_EN
    if (state_nxt == PARITY) so_nxt = par_nxt;
    final_nxt = (state_nxt == PARITY);
`else
    final_nxt = (state_nxt == SHIFT) && (cnt_nxt == '0);
`endif
    rdy_nxt = (state_nxt == IDLE) || final_nxt;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      Serial_Out  <= 1'b0;
      Out_Valid   <= 1'b0;
      Frame_Start <= 1'b0;
      Busy        <= 1'b0;
      In_Ready    <= 1'b0;
    end else begin
      Serial_Out  <= so_nxt;
      Out_Valid   <= ov_nxt;
      Frame_Start <= fs_nxt;
      Busy        <= busy_nxt;
      In_Ready    <= rdy_nxt;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances checked against a bit-queue model,
// plus literal frame expectations. Honours PISO_SERIALIZER_PARITY_EN like the design.
module tb_piso_serializer;

`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int FL = 5;
  localparam logic [FL-1:0] M1011 = 5'b10111, L1011 = 5'b11011, M0100 = 5'b01001;
  localparam logic [FL-1:0] M0110 = 5'b01100, L0110 = 5'b01100, M1001 = 5'b10010;
`else
  localparam int FL = 4;
  localparam logic [FL-1:0] M1011 = 4'b1011, L1011 = 4'b1101, M0100 = 4'b0100;
  localparam logic [FL-1:0] M0110 = 4'b0110, L0110 = 4'b0110, M1001 = 4'b1001;
`endif

  logic       Clock = 1'b0, Reset = 1'b0, In_Valid = 1'b0;
  logic [3:0] Data_In = 4'b0;
  logic       rdy_m, so_m, ov_m, fs_m, bz_m;
  logic       rdy_l, so_l, ov_l, fs_l, bz_l;

  int checks = 0, errors = 0, cyc = 0;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .Clock(Clock), .Reset(Reset), .Data_In(Data_In), .In_Valid(In_Valid),
    .In_Ready(rdy_m), .Serial_Out(so_m), .Out_Valid(ov_m), .Frame_Start(fs_m), .Busy(bz_m));

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .Clock(Clock), .Reset(Reset), .Data_In(Data_In), .In_Valid(In_Valid),
    .In_Ready(rdy_l), .Serial_Out(so_l), .Out_Valid(ov_l), .Frame_Start(fs_l), .Busy(bz_l));

  always #5 Clock = ~Clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: each accepted word becomes a queue of {frame_start, bit}; one entry leaves per cycle.
  function automatic logic [FL-1:0] frame_bits(input logic [3:0] w, input bit msb);
    logic [FL-1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[FL-1-i] = msb ? w[3-i] : w[i];
`ifdef PISO_SERIALIZER_PARITY_EN
    r[0] = ^w;
`endif
    return r;
  endfunction

  logic [1:0] q_m[$], q_l[$];
  bit e_rdy = 1'b0;

  always @(posedge Clock) begin
    logic [FL-1:0] fm, fl;
    bit acc;
    cyc++;
    if (!Reset) begin
      q_m.delete();
      q_l.delete();
      e_rdy = 1'b0;
    end else begin
      acc = In_Valid && e_rdy;
      if (q_m.size() > 0) void'(q_m.pop_front());
      if (q_l.size() > 0) void'(q_l.pop_front());
      if (acc) begin
        fm = frame_bits(Data_In, 1'b1);
        fl = frame_bits(Data_In, 1'b0);
        for (int i = 0; i < FL; i++) begin
          q_m.push_back({i == 0, fm[FL-1-i]});
          q_l.push_back({i == 0, fl[FL-1-i]});
        end
      end
      e_rdy = (q_m.size() <= 1);
    end
  end

  logic cap_m[0:255], cap_l[0:255], cap_f[0:255];
  int   cap_c[0:255];
  int   cap_n = 0;

  always @(negedge Clock) begin
    if (cyc > 0) begin
      chk("msb_out_valid", ov_m, q_m.size() > 0);
      chk("msb_serial_out", so_m, q_m.size() > 0 ? q_m[0][0] : 1'b0);
      chk("msb_frame_start", fs_m, q_m.size() > 0 ? q_m[0][1] : 1'b0);
      chk("msb_busy", bz_m, q_m.size() > 0);
      chk("msb_in_ready", rdy_m, e_rdy);
      chk("lsb_out_valid", ov_l, q_l.size() > 0);
      chk("lsb_serial_out", so_l, q_l.size() > 0 ? q_l[0][0] : 1'b0);
      chk("lsb_frame_start", fs_l, q_l.size() > 0 ? q_l[0][1] : 1'b0);
      chk("lsb_in_ready", rdy_l, e_rdy);
    end
    if (ov_m === 1'b1 && cap_n < 256) begin
      cap_m[cap_n] = so_m;
      cap_l[cap_n] = so_l;
      cap_f[cap_n] = fs_m;
      cap_c[cap_n] = cyc;
      cap_n++;
    end
  end

  function automatic logic [31:0] grab(input int s, input int n, input bit lsb);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[n-1-i] = lsb ? cap_l[s+i] : cap_m[s+i];
    return r;
  endfunction

  function automatic int starts(input int s, input int n);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) if (cap_f[s+i]) c++;
    return c;
  endfunction

  task automatic send(input logic [3:0] w);
    int n;
    Data_In  = w;
    In_Valid = 1'b1;
    n = 0;
    while (rdy_m !== 1'b1 && n < 40) begin
      @(negedge Clock);
      n++;
    end
    chk("send_handshake_timeout", n < 40, 1'b1);
    @(negedge Clock);
  endtask

  initial begin
    int s;
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    chk("reset_in_ready", rdy_m, 1'b0);
    chk("reset_out_valid", ov_m, 1'b0);
    chk("reset_serial_out", so_m, 1'b0);
    chk("reset_busy", bz_m, 1'b0);
    Reset = 1'b1;
    @(negedge Clock);
    chk("release_in_ready", rdy_m, 1'b1);

    // basic frame
    s = cap_n;
    send(4'b1011);
    In_Valid = 1'b0;
    repeat (FL + 2) @(negedge Clock);
    chk("basic_len", cap_n - s, FL);
    chk("basic_msb_bits", grab(s, FL, 1'b0), 32'(M1011));
    chk("basic_lsb_bits", grab(s, FL, 1'b1), 32'(L1011));
    chk("basic_frame_starts", starts(s, FL), 1);
    chk("basic_first_start", cap_f[s], 1'b1);
    chk("basic_idle_busy", bz_m, 1'b0);

    // back-to-back frames
    s = cap_n;
    send(4'b1011);
    send(4'b0100);
    In_Valid = 1'b0;
    repeat (FL + 2) @(negedge Clock);
    chk("b2b_len", cap_n - s, 2 * FL);
    chk("b2b_bits", grab(s, 2 * FL, 1'b0), 32'({M1011, M0100}));
    chk("b2b_contiguous", cap_c[s + 2*FL - 1] - cap_c[s], 2 * FL - 1);
    chk("b2b_frame_starts", starts(s, 2 * FL), 2);
    chk("b2b_second_start", cap_f[s + FL], 1'b1);

    // LSB-first order
    s = cap_n;
    send(4'b0110);
    In_Valid = 1'b0;
    repeat (FL + 2) @(negedge Clock);
    chk("lsb_bits", grab(s, FL, 1'b1), 32'(L0110));
    chk("lsb_msb_inst_bits", grab(s, FL, 1'b0), 32'(M0110));

    // Data_In changes mid-frame
    s = cap_n;
    send(4'b1001);
    In_Valid = 1'b0;
    @(negedge Clock);
    Data_In = 4'b1111;
    repeat (FL + 2) @(negedge Clock);
    chk("stable_bits", grab(s, FL, 1'b0), 32'(M1001));

    // reset after two bits
    s = cap_n;
    send(4'b1111);
    In_Valid = 1'b0;
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    chk("midrst_out_valid", ov_m, 1'b0);
    chk("midrst_serial_out", so_m, 1'b0);
    chk("midrst_in_ready", rdy_m, 1'b0);
    chk("midrst_bits_before", cap_n - s, 2);
    Reset = 1'b1;
    @(negedge Clock);
    chk("midrst_release_ready", rdy_m, 1'b1);
    chk("midrst_release_valid", ov_m, 1'b0);
    repeat (FL + 2) @(negedge Clock);
    chk("midrst_no_tail", cap_n - s, 2);

    // continuous stream checked by the model
    foreach (Data_In[i]) begin end
    send(4'h0);
    send(4'hF);
    send(4'h5);
    send(4'hA);
    send(4'h3);
    In_Valid = 1'b0;
    repeat (FL + 4) @(negedge Clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d errors so far", errors);
    $fatal(1);
  end

endmodule
